// File: rtl/count_chk_pkg.sv
// Shared types, default sizes and the counter step function for the count checker
// and for any model of the 4-bit loadable up/down counter it watches.
package count_chk_pkg;

  localparam int DEF_W      = 4;
  localparam int DEF_LOCK_N = 3;
  localparam int DEF_ECW    = 8;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } chk_state_e;

  // Returns value +/- 1 at full 32-bit width; callers truncate to their
  // own width, which yields the modulo-2^W wrap in both directions.
  function automatic logic [31:0] next_count(input logic [31:0] value,
                                             input logic        updown);
    return updown ? (value + 32'd1) : (value - 32'd1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear; clear has priority over increment.
module sat_counter #(
  parameter int ECW = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           inc,
  input  logic           clr,
  output logic [ECW-1:0] count
);

  logic [ECW-1:0] count_q;
  logic [ECW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {ECW{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/count_checker.sv
// Monitor for an up/down/loadable counter stream: predicts each next sample,
// locks after LOCK_N consecutive matches and reports mismatches seen while locked.
module count_checker
  import count_chk_pkg::*;
#(
  parameter int W      = DEF_W,
  parameter int LOCK_N = DEF_LOCK_N,
  parameter int ECW    = DEF_ECW
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           valid,
  input  logic [W-1:0]   count_in,
  input  logic           updown,
  input  logic           load,
  input  logic [W-1:0]   load_val,
  input  logic           err_clr,
  output logic           locked,
  output logic           err,
  output logic           sticky_err,
  output logic [ECW-1:0] err_count,
  output logic [W-1:0]   expected
);

  localparam int MCW = 4;

  chk_state_e     state_q, state_d;
  logic           primed_q, primed_d;
  logic [MCW-1:0] match_q, match_d;
  logic [W-1:0]   expected_q, expected_d;
  logic           err_q, err_d;
  logic           sticky_q, sticky_d;

  logic [W-1:0]   pred;
  logic [MCW-1:0] match_inc;
  logic           hit;

  // Prediction always comes from the observed sample so one bad value resyncs.
  assign pred      = load ? load_val : W'(next_count(32'(count_in), updown));
  assign hit       = (count_in == expected_q);
  assign match_inc = match_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    primed_d   = primed_q;
    match_d    = match_q;
    expected_d = expected_q;
    err_d      = 1'b0;
    if (valid) begin
      expected_d = pred;
      case (state_q)
        UNLOCKED: begin
          if (!primed_q) begin
            primed_d = 1'b1;
            match_d  = '0;
          end else if (hit) begin
            if (match_inc == MCW'(LOCK_N)) begin
              state_d = LOCKED;
              match_d = '0;
            end else begin
              match_d = match_inc;
            end
          end else begin
            match_d = '0;
          end
        end
        LOCKED: begin
          if (!hit) begin
            err_d   = 1'b1;
            state_d = UNLOCKED;
            match_d = '0;
          end
        end
        default: state_d = UNLOCKED;
      endcase
    end
  end

  // A clear in the same cycle as an error event wins over the set.
  always_comb begin
    sticky_d = sticky_q;
    if (err_clr) begin
      sticky_d = 1'b0;
    end else if (err_d) begin
      sticky_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= UNLOCKED;
      primed_q   <= 1'b0;
      match_q    <= '0;
      expected_q <= '0;
      err_q      <= 1'b0;
      sticky_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      primed_q   <= primed_d;
      match_q    <= match_d;
      expected_q <= expected_d;
      err_q      <= err_d;
      sticky_q   <= sticky_d;
    end
  end

  sat_counter #(
    .ECW(ECW)
  ) u_err_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (err_d),
    .clr  (err_clr),
    .count(err_count)
  );

  assign locked     = (state_q == LOCKED);
  assign err        = err_q;
  assign sticky_err = sticky_q;
  assign expected   = expected_q;

endmodule

// File: doc/count_checker.md
Name: count_checker

Overview:
- Receiving-end monitor for the 4-bit loadable up/down counter stream.
- Samples the counter's output each valid cycle, predicts the next value from the direction/load controls, and flags sequence violations.
- Sits beside the counter in the datapath and feeds status and error statistics to the control/debug logic.

Parameters:
- W, 4, width of observed count and load value.
- LOCK_N, 3, consecutive matching samples required to enter LOCKED (range 1..15).
- ECW, 8, width of saturating error counter.

Ports:
- clk  input  1  single clock, all state on posedge.
- reset  input  1  asynchronous, active-low reset; reset==0 clears all state immediately.
- valid  input  1  count_in/updown/load are meaningful this cycle.
- count_in  input  W  observed counter output.
- updown  input  1  direction applied to the next step: 1 = up (+1), 0 = down (-1).
- load  input  1  counter is being loaded this cycle; the next sample equals load_val.
- load_val  input  W  value the counter loads.
- err_clr  input  1  synchronous clear of err_count and sticky_err.
- locked  output  1  checker is in LOCKED state.
- err  output  1  one-cycle pulse, registered, for a mismatch detected in LOCKED.
- sticky_err  output  1  set on any err; held until err_clr or reset.
- err_count  output  ECW  saturating mismatch count.
- expected  output  W  predicted value of the next valid sample.

Behaviour:
- Reset (reset==0, asynchronous): state=UNLOCKED; locked=0, err=0, sticky_err=0, err_count=0, expected=0, match counter=0.
- All arithmetic is modulo 2^W. Up from 2^W-1 wraps to 0; down from 0 wraps to 2^W-1. Wrap is legal, not an error.
- Prediction on each valid sample: expected_next = load ? load_val : (updown ? count_in+1 : count_in-1).
- Prediction is always built from the observed count_in, not the old expected, so a checker resyncs after one bad sample.
- valid==0: all state holds; err deasserts.

FSM states and transitions:
- UNLOCKED:
  - First valid sample: no compare; expected := expected_next; match counter := 0.
  - Subsequent valid samples: compare count_in against expected. On match, match counter +1; on mismatch, match counter := 0 and no err.
  - When the match counter reaches LOCK_N, go to LOCKED.
- LOCKED:
  - Valid sample with count_in==expected: stay; update expected.
  - Mismatch: err=1 on the next cycle; err_count +1, saturating at 2^ECW-1; sticky_err=1; go to UNLOCKED with match counter=0; expected := expected_next from the current sample.
- locked is a registered state decode. It rises the cycle after the LOCK_N-th match and falls the cycle after a mismatch.
- A load sample is still compared against the prior prediction. The load only affects the next prediction.
- Simultaneous err event and err_clr: err_clr wins for err_count/sticky_err (both go 0); the err pulse still fires.
- Saturated err_count stays at its maximum value; sticky_err remains 1.
- Reset mid-operation: immediate return to reset values, regardless of state.
- Latency: err, locked and expected update 1 cycle after the sample edge.

Decomposition:
- Package count_chk_pkg holds:
  - the state enum (UNLOCKED, LOCKED);
  - default W/LOCK_N/ECW constants;
  - a next_count(value, updown) function shared with the counter testbench model.
- One sub-module is natural: sat_counter (parameterised ECW, inc, clr, saturating), used for err_count.
- The FSM and predictor stay in the top module.

Test Plan:
- Lock-up: reset, then valid up-stream 3,4,5,6 (updown=1) -> locked=1 the cycle after sample 6; err=0; expected=7.
- Wrap: locked, up-stream 14,15,0,1 then down-stream 1,0,15 -> no err, locked stays 1, expected=14 at the end.
- Mismatch: locked with expected=8, count_in=10 -> err pulse one cycle, err_count=1, sticky_err=1, locked=0, expected=11. Then 11,12,13 -> locked=1 again.
- Load: locked at 5 with load=1, load_val=9, then sample 9 -> no err. If a sample of 6 follows instead -> err, err_count increments.
- Saturation/clear: with ECW=2, force 5 mismatches -> err_count=3 and held. Assert err_clr in the same cycle as a mismatch -> err pulses, err_count=0, sticky_err=0.
- Async reset mid-stream: drop reset between clock edges while locked -> outputs go to reset values immediately. After release, the first valid sample produces no err.
